// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one 32-bit word per instruction
// over a req/ack handshake, holds it until the datapath retires it, then picks
// the next PC from the branch/jump decision. A fetch that goes unanswered for
// TIMEOUT cycles parks the unit in a terminal error state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic        i_zero,
    input  logic        i_retire,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_fetch_error
);

    // Low bits forced to zero so the PC is always word aligned.
    localparam logic [31:0] RstPc = {RESET_PC[31:2], 2'b00};
    // Counter value seen on the last cycle a fetch may still be acked.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StError
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_req, w_req_nxt;
    logic        r_err, w_err_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    // Next PC selection: jump beats taken branch beats sequential.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (i_jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (i_branch && i_zero) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for all registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        w_req_nxt   = r_req;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StIdle: begin
                w_state_nxt = StFetch;
                w_req_nxt   = 1'b1;
                w_cnt_nxt   = 16'd0;
            end
            StFetch: begin
                // Ack is checked first so it wins over a same-cycle timeout.
                if (i_imem_ack) begin
                    w_instr_nxt = i_imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = StExec;
                end else if (r_cnt == TimeoutLast) begin
                    w_err_nxt   = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = StError;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            StExec: begin
                if (i_retire) begin
                    w_pc_nxt    = w_next_pc;
                    w_valid_nxt = 1'b0;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = StFetch;
                end
            end
            StError: begin
                w_req_nxt   = 1'b0;
                w_valid_nxt = 1'b0;
                w_err_nxt   = 1'b1;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RstPc;
            r_instr <= 32'd0;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_req   <= w_req_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_valid;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_fetch_error = r_err;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the controller. It holds the program counter and fetches 32-bit instructions from instruction memory over a req/ack handshake. It presents each instruction on `instr` to the controller and datapath until the datapath retires it. It then selects the next PC from the controller's `branch`/`jump` decisions and the ALU `zero` flag.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `TIMEOUT`, 255, cycles `FETCH` waits for `imem_ack` before declaring an error (1..65535).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `branch`  in  1  controller: current instruction is a conditional branch.
- `jump`  in  1  controller: current instruction is a jump.
- `zero`  in  1  ALU zero flag for the current instruction.
- `retire`  in  1  datapath has finished the current instruction; sampled only in `EXEC`.
- `imem_req`  out  1  fetch request; held high until ack.
- `imem_addr`  out  32  fetch address, equal to `pc`.
- `imem_ack`  in  1  memory returns data this cycle; sampled only in `FETCH`.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `instr`  out  32  registered instruction to the controller and datapath.
- `instr_valid`  out  1  `instr` holds an unretired instruction.
- `pc`  out  32  address of the current or in-flight instruction.
- `pc_plus4`  out  32  `pc + 4`, combinational, mod 2^32.
- `fetch_error`  out  1  sticky timeout flag.

## Operation
- States: `IDLE`, `FETCH`, `EXEC`, `ERROR`.
- Reset (asynchronous): state=`IDLE`, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0, `fetch_error`=0, wait counter=0.
- `IDLE` → `FETCH` unconditionally on the first clock after `rst_n` rises.
- `FETCH`:
  - `imem_req`=1 and `imem_addr`=`pc`, both stable until ack.
  - On `imem_ack`: `instr`←`imem_rdata`, `instr_valid`←1, counter←0, go to `EXEC`.
  - Otherwise counter increments. When the counter reaches `TIMEOUT` without ack: `fetch_error`←1, `imem_req`←0, go to `ERROR`.
  - If ack arrives in the same cycle the counter reaches `TIMEOUT`, the ack wins.
- `EXEC`:
  - `instr` and `instr_valid` are held.
  - On `retire`: `pc`←next_pc, `instr_valid`←0, go to `FETCH`.
- next_pc priority:
  - `jump`=1 → {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  - else `branch` & `zero` → `pc_plus4` + (sign-extended `instr`[15:0] << 2), mod 2^32.
  - else → `pc_plus4`.
- `ERROR`: terminal. `imem_req`=0, `instr_valid`=0, `fetch_error`=1; only reset exits.
- Ignored inputs: `imem_ack` outside `FETCH`, `retire` outside `EXEC`, and `branch`/`jump`/`zero` except on the retire cycle.
- Arithmetic: all PC arithmetic is 32-bit with silent wrap (0xFFFF_FFFC + 4 = 0). `pc`[1:0] stays 00.

## Timing
- Every output is a register except `imem_addr` (= `pc`) and `pc_plus4`.
- Ack in cycle N → `instr_valid`=1 and `instr` updated in N+1.
- Retire in cycle M → new `pc` and `imem_req`=1 in M+1.
- Throughput: 2 cycles per instruction minimum (zero-wait memory, retire on the first `EXEC` cycle).
- Reset asserted mid-`FETCH` or mid-`EXEC` clears all state immediately. The in-flight request is abandoned, and a late ack after reset release is ignored unless state is `FETCH`.

## Test plan
- Reset and first fetch: release `rst_n`, memory acks on the 2nd `FETCH` cycle with 0x2008_0005 → `imem_addr`=0x0 while requesting; `instr`=0x2008_0005 and `instr_valid`=1 one cycle after ack.
- Sequential flow: retire three instructions with branch=jump=0 → `imem_addr` sequence 0x0, 0x4, 0x8, 0xC.
- Branch at pc=0x10, `instr`[15:0]=0xFFFE:
  - zero=1 → next `pc`=0x0C.
  - zero=0 → next `pc`=0x14.
- Jump at pc=0x4000_0000 with `instr`[25:0]=0x0000100 → next `pc`=0x4000_0400. Also assert branch=zero=1 in the same retire and confirm jump wins.
- Timeout with `TIMEOUT`=4 and no ack → `fetch_error`=1 and `imem_req`=0 after 4 `FETCH` cycles, and they stay there.
  - Repeat with ack on exactly the 4th cycle → `EXEC` entered, no error.
- Wrap and reset: `RESET_PC`=0xFFFF_FFFC, retire → `pc`=0.
  - Assert `rst_n`=0 mid-`EXEC` → `instr_valid`=0 and `pc`=`RESET_PC` immediately, without a clock edge.
